// File: rtl/dense_axis_tx.sv
// Small generic synchronous FIFO with occupancy count; head is the oldest entry.
// Latency: a pushed word is visible at head_dat on the cycle after the push.
// Backpressure: none internally; the caller must never push when full or pop when empty.
module fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_vld,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  head_dat,
    output logic [CW-1:0] cnt
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_vld) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push_vld, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign head_dat = mem[rd_ptr];
endmodule

// Streams OUT_COUNT words from the dense outputs RAM as one AXI4-Stream packet.
// Latency: start at edge E0 -> first tvalid 3 cycles later; done OUT_COUNT+3 cycles after start.
// Backpressure: tready=0 stops RAM reads once 2 words are buffered; resumes gap-free.
module dense_axis_tx #(
    parameter int DATA_SIZE = 32,
    parameter int OUT_COUNT = 3,
    parameter int ADR_W     = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 buf_rd,
    output logic [ADR_W-1:0]     buf_adr,
    input  logic [DATA_SIZE-1:0] buf_data,
    output logic [DATA_SIZE-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast
);
    localparam int                CNT_W = $clog2(OUT_COUNT + 1);
    localparam logic [CNT_W-1:0] COUNT = CNT_W'(OUT_COUNT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(OUT_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CNT_W-1:0]     rd_cnt;
    logic [CNT_W-1:0]     tx_cnt;
    logic                 inflight;
    logic                 start_ok;
    logic                 pop;
    logic                 rd_en;
    logic [2:0]           room_used;
    logic [1:0]           fifo_cnt;
    logic [DATA_SIZE-1:0] head_dat;

    assign start_ok  = start && ((state == IDLE) || (state == FIN));
    assign pop       = m_axis_tvalid && m_axis_tready;
    // Words already buffered or on their way, after this cycle's pop.
    assign room_used = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign rd_en     = (state == RUN) && (rd_cnt < COUNT) && (room_used < 3'd2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (pop && (tx_cnt == LAST)) state_nxt = FIN;
            FIN:     state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy          = (state == RUN);
        done          = (state == FIN);
        buf_rd        = rd_en;
        buf_adr       = rd_en ? ADR_W'(rd_cnt) : '0;
        m_axis_tvalid = (fifo_cnt != 2'd0);
        m_axis_tdata  = m_axis_tvalid ? head_dat : '0;
        m_axis_tlast  = m_axis_tvalid && (tx_cnt == LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt   <= '0;
            tx_cnt   <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= rd_en;
            if (start_ok) begin
                rd_cnt <= '0;
                tx_cnt <= '0;
            end else begin
                if (rd_en) rd_cnt <= rd_cnt + CNT_W'(1);
                if (pop)   tx_cnt <= tx_cnt + CNT_W'(1);
            end
        end
    end

    fifo #(
        .W     (DATA_SIZE),
        .DEPTH (2),
        .CW    (2)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (inflight),
        .push_dat (buf_data),
        .pop      (pop),
        .head_dat (head_dat),
        .cnt      (fifo_cnt)
    );
endmodule

// File: tb/tb_dense_axis_tx.sv
// Directed bench for dense_axis_tx: a 3-beat instance and a 1-beat instance,
// each fed by a registered-read RAM model.
module tb_dense_axis_tx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start3, busy3, done3, buf_rd3, tvalid3, tready3, tlast3;
    logic [4:0]  buf_adr3;
    logic [31:0] buf_data3, tdata3;
    logic        start1, busy1, done1, buf_rd1, tvalid1, tready1, tlast1;
    logic [4:0]  buf_adr1;
    logic [31:0] buf_data1, tdata1;
    logic [31:0] ram3 [4];

    int npass  = 0;
    int ntotal = 0;
    int nreads;

    dense_axis_tx #(.DATA_SIZE(32), .OUT_COUNT(3), .ADR_W(5)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .busy(busy3), .done(done3),
        .buf_rd(buf_rd3), .buf_adr(buf_adr3), .buf_data(buf_data3),
        .m_axis_tdata(tdata3), .m_axis_tvalid(tvalid3),
        .m_axis_tready(tready3), .m_axis_tlast(tlast3)
    );

    dense_axis_tx #(.DATA_SIZE(32), .OUT_COUNT(1), .ADR_W(5)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .buf_rd(buf_rd1), .buf_adr(buf_adr1), .buf_data(buf_data1),
        .m_axis_tdata(tdata1), .m_axis_tvalid(tvalid1),
        .m_axis_tready(tready1), .m_axis_tlast(tlast1)
    );

    always @(posedge clk) begin
        if (buf_rd3) buf_data3 <= ram3[buf_adr3[1:0]];
        if (buf_rd1) buf_data1 <= (buf_adr1 == 5'd0) ? 32'h5 : 32'hDEAD;
    end

    // Control snapshot: {busy, done, buf_rd, tvalid, tlast, buf_adr}
    function automatic logic [31:0] ctl3();
        return {22'd0, busy3, done3, buf_rd3, tvalid3, tlast3, buf_adr3};
    endfunction

    function automatic logic [31:0] ctl1();
        return {22'd0, busy1, done1, buf_rd1, tvalid1, tlast1, buf_adr1};
    endfunction

    function automatic logic [31:0] ex(input logic [4:0] f, input logic [4:0] a);
        return {22'd0, f, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) begin
            npass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic st, input logic rdy);
        @(negedge clk);
        start3  = st;
        tready3 = rdy;
        #1;
    endtask

    // Full packet with tready held high, start on c0.
    task automatic std_packet(input string t);
        step(1'b1, 1'b1); chk({t, " c0"}, ctl3(), ex(5'b00000, 5'd0));
        step(1'b0, 1'b1); chk({t, " c1"}, ctl3(), ex(5'b10100, 5'd0));
        step(1'b0, 1'b1); chk({t, " c2"}, ctl3(), ex(5'b10100, 5'd1));
        step(1'b0, 1'b1); chk({t, " c3"}, ctl3(), ex(5'b10110, 5'd2));
        chk({t, " c3 data"}, tdata3, 32'hA);
        step(1'b0, 1'b1); chk({t, " c4"}, ctl3(), ex(5'b10010, 5'd0));
        chk({t, " c4 data"}, tdata3, 32'hB);
        step(1'b0, 1'b1); chk({t, " c5"}, ctl3(), ex(5'b10011, 5'd0));
        chk({t, " c5 data"}, tdata3, 32'hC);
        step(1'b0, 1'b1); chk({t, " c6"}, ctl3(), ex(5'b01000, 5'd0));
        step(1'b0, 1'b1); chk({t, " c7"}, ctl3(), ex(5'b00000, 5'd0));
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ram3[0] = 32'hA; ram3[1] = 32'hB; ram3[2] = 32'hC; ram3[3] = 32'hEEEE;
        rst = 1'b1; start3 = 1'b0; tready3 = 1'b1; start1 = 1'b0; tready1 = 1'b1;
        #1 rst = 1'b0;
        #2;
        chk("reset ctl3", ctl3(), ex(5'b00000, 5'd0));
        chk("reset tdata3", tdata3, 32'h0);
        chk("reset ctl1", ctl1(), ex(5'b00000, 5'd0));
        chk("reset tdata1", tdata1, 32'h0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        @(negedge clk) rst = 1'b1;

        // 1: basic packet
        std_packet("t1");

        // 2: tready toggles 1/0 each cycle
        step(1'b1, 1'b1); chk("t2 c0", ctl3(), ex(5'b00000, 5'd0));
        step(1'b0, 1'b0); chk("t2 c1", ctl3(), ex(5'b10100, 5'd0));
        step(1'b0, 1'b1); chk("t2 c2", ctl3(), ex(5'b10100, 5'd1));
        step(1'b0, 1'b0); chk("t2 c3", ctl3(), ex(5'b10010, 5'd0));
        chk("t2 c3 data", tdata3, 32'hA);
        step(1'b0, 1'b1); chk("t2 c4", ctl3(), ex(5'b10110, 5'd2));
        chk("t2 c4 data", tdata3, 32'hA);
        step(1'b0, 1'b0); chk("t2 c5", ctl3(), ex(5'b10010, 5'd0));
        chk("t2 c5 data", tdata3, 32'hB);
        step(1'b0, 1'b1); chk("t2 c6", ctl3(), ex(5'b10010, 5'd0));
        chk("t2 c6 data", tdata3, 32'hB);
        step(1'b0, 1'b0); chk("t2 c7", ctl3(), ex(5'b10011, 5'd0));
        chk("t2 c7 data", tdata3, 32'hC);
        step(1'b0, 1'b1); chk("t2 c8", ctl3(), ex(5'b10011, 5'd0));
        chk("t2 c8 data", tdata3, 32'hC);
        step(1'b0, 1'b0); chk("t2 c9", ctl3(), ex(5'b01000, 5'd0));
        step(1'b0, 1'b1); chk("t2 c10", ctl3(), ex(5'b00000, 5'd0));

        // 3: tready low for 20 cycles
        step(1'b1, 1'b0);
        nreads = 0;
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, 1'b0);
            if (buf_rd3) nreads++;
        end
        chk("t3 reads while stalled", nreads, 32'd2);
        chk("t3 stalled ctl", ctl3(), ex(5'b10010, 5'd0));
        chk("t3 stalled data", tdata3, 32'hA);
        step(1'b0, 1'b1); chk("t3 r0", ctl3(), ex(5'b10110, 5'd2));
        chk("t3 r0 data", tdata3, 32'hA);
        step(1'b0, 1'b1); chk("t3 r1", ctl3(), ex(5'b10010, 5'd0));
        chk("t3 r1 data", tdata3, 32'hB);
        step(1'b0, 1'b1); chk("t3 r2", ctl3(), ex(5'b10011, 5'd0));
        chk("t3 r2 data", tdata3, 32'hC);
        step(1'b0, 1'b1); chk("t3 r3", ctl3(), ex(5'b01000, 5'd0));
        step(1'b0, 1'b1); chk("t3 r4", ctl3(), ex(5'b00000, 5'd0));

        // 4: start during RUN ignored, start during FIN accepted
        step(1'b1, 1'b1);
        step(1'b0, 1'b1); chk("t4 c1", ctl3(), ex(5'b10100, 5'd0));
        step(1'b1, 1'b1); chk("t4 c2", ctl3(), ex(5'b10100, 5'd1));
        step(1'b0, 1'b1); chk("t4 c3", ctl3(), ex(5'b10110, 5'd2));
        step(1'b0, 1'b1); chk("t4 c4", ctl3(), ex(5'b10010, 5'd0));
        step(1'b0, 1'b1); chk("t4 c5", ctl3(), ex(5'b10011, 5'd0));
        step(1'b1, 1'b1); chk("t4 c6 fin", ctl3(), ex(5'b01000, 5'd0));
        step(1'b0, 1'b1); chk("t4 c7", ctl3(), ex(5'b10100, 5'd0));
        step(1'b0, 1'b1); chk("t4 c8", ctl3(), ex(5'b10100, 5'd1));
        step(1'b0, 1'b1); chk("t4 c9", ctl3(), ex(5'b10110, 5'd2));
        chk("t4 c9 data", tdata3, 32'hA);
        step(1'b0, 1'b1); chk("t4 c10 data", tdata3, 32'hB);
        step(1'b0, 1'b1); chk("t4 c11", ctl3(), ex(5'b10011, 5'd0));
        chk("t4 c11 data", tdata3, 32'hC);
        step(1'b0, 1'b1); chk("t4 c12", ctl3(), ex(5'b01000, 5'd0));
        step(1'b0, 1'b1); chk("t4 c13", ctl3(), ex(5'b00000, 5'd0));

        // 5: reset mid-packet after beat 1
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1); chk("t5 beat0", tdata3, 32'hA);
        step(1'b0, 1'b1); chk("t5 beat1", tdata3, 32'hB);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t5 rst ctl", ctl3(), ex(5'b00000, 5'd0));
        chk("t5 rst data", tdata3, 32'h0);
        step(1'b0, 1'b1); chk("t5 rst hold1", ctl3(), ex(5'b00000, 5'd0));
        step(1'b0, 1'b1); chk("t5 rst hold2", ctl3(), ex(5'b00000, 5'd0));
        @(negedge clk) rst = 1'b1;
        #1 chk("t5 post rst", ctl3(), ex(5'b00000, 5'd0));
        std_packet("t5 restart");

        // 6: single-beat instance
        @(negedge clk); start1 = 1'b1; #1;
        chk("t6 c0", ctl1(), ex(5'b00000, 5'd0));
        @(negedge clk); start1 = 1'b0; #1;
        chk("t6 c1", ctl1(), ex(5'b10100, 5'd0));
        @(negedge clk); #1;
        chk("t6 c2", ctl1(), ex(5'b10000, 5'd0));
        @(negedge clk); #1;
        chk("t6 c3", ctl1(), ex(5'b10011, 5'd0));
        chk("t6 c3 data", tdata1, 32'h5);
        @(negedge clk); #1;
        chk("t6 c4", ctl1(), ex(5'b01000, 5'd0));
        @(negedge clk); #1;
        chk("t6 c5", ctl1(), ex(5'b00000, 5'd0));

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
